// File: rtl/barrel_coord_gen_pkg.sv
// Shared types and default geometry for the barrel-distortion coordinate generator.
// Both the generator and the memory interface are sized from these defaults.
package barrel_coord_gen_pkg;

    localparam int DEF_WIDTH       = 1080;
    localparam int DEF_HEIGHT      = 960;
    localparam int DEF_MEM_LATENCY = 2;
    localparam int DEF_BOW_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Sideband carried alongside each request until the memory returns its pixel.
    typedef struct packed {
        logic valid;
        logic last;
        logic user;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/barrel_coord_gen_if.sv
// Request/response signals between the coordinate generator and the line buffer / AXIS sink.
interface barrel_coord_gen_if #(
    parameter int XW = 12,
    parameter int YW = 11
);
    logic          Math_Ready;
    logic          AXIS_Out_Ready;
    logic [XW-1:0] Math_X;
    logic [YW-1:0] Math_Y;
    logic          Pixel_Valid;
    logic          Pixel_Last;
    logic          Pixel_User;

    modport master (
        input  Math_Ready, AXIS_Out_Ready,
        output Math_X, Math_Y, Pixel_Valid, Pixel_Last, Pixel_User
    );

    modport slave (
        output Math_Ready, AXIS_Out_Ready,
        input  Math_X, Math_Y, Pixel_Valid, Pixel_Last, Pixel_User
    );
endinterface

// File: rtl/barrel_bow_rom.sv
// Per-column signed vertical bow offset, read combinationally (distributed ROM).
// Entry i occupies bow_init[i*bow_bits +: bow_bits].
module barrel_bow_rom #(
    parameter int width    = 1080,
    parameter int bow_bits = 8,
    parameter int AW       = $clog2(width),
    parameter logic [width*bow_bits-1:0] bow_init = '0
) (
    input  logic        [AW-1:0]       addr,
    output logic signed [bow_bits-1:0] data
);

    always_comb begin
        data = $signed(bow_init[int'(addr)*bow_bits +: bow_bits]);
    end

endmodule

// File: rtl/barrel_coord_gen.sv
// Raster-scan request generator: walks the frame, applies the column bow to the row,
// and delays the valid/last/user tag so it lines up with the memory's output pixel.
module barrel_coord_gen
    import barrel_coord_gen_pkg::*;
#(
    parameter int width       = DEF_WIDTH,
    parameter int height      = DEF_HEIGHT,
    parameter int mem_latency = DEF_MEM_LATENCY,
    parameter int bow_bits    = DEF_BOW_BITS,
    parameter logic [width*bow_bits-1:0] bow_init = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Enable,
    barrel_coord_gen_if.master bus,
    output logic               Frame_Done,
    output logic               Busy
);

    localparam int UW = $clog2(width);
    localparam int XW = UW + 1;
    localparam int VW = $clog2(height);
    localparam int YW = VW + 1;
    localparam int SW = VW + 2;
    localparam int DW = $clog2(mem_latency + 1) + 1;

    localparam logic        [UW-1:0] U_LAST = UW'(width - 1);
    localparam logic        [VW-1:0] V_LAST = VW'(height - 1);
    localparam logic signed [SW-1:0] Y_MAX  = SW'(height - 1);

    state_e                state_q, state_d;
    logic [UW-1:0]         u_q, u_d;
    logic [VW-1:0]         v_q, v_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  done_q, done_d;
    logic [XW-1:0]         math_x_q, math_x_d;
    logic [YW-1:0]         math_y_q, math_y_d;
    tag_t                  tag_q [mem_latency+1];
    tag_t                  tag_d [mem_latency+1];

    logic                  en;
    logic                  issue;
    logic signed [bow_bits-1:0] bow;
    logic signed [SW-1:0]  y_sum;

    function automatic logic [YW-1:0] clamp_row(input logic signed [SW-1:0] s);
        if (s < 0)
            return '0;
        if (s > Y_MAX)
            return YW'(height - 1);
        return s[YW-1:0];
    endfunction

    barrel_bow_rom #(
        .width    (width),
        .bow_bits (bow_bits),
        .AW       (UW),
        .bow_init (bow_init)
    ) u_bow_rom (
        .addr (u_q),
        .data (bow)
    );

    assign en    = bus.AXIS_Out_Ready;
    assign issue = en && (state_q == ST_RUN) && bus.Math_Ready;
    assign y_sum = $signed({2'b00, v_q}) + SW'(bow);

    always_comb begin
        state_d  = state_q;
        u_d      = u_q;
        v_d      = v_q;
        drain_d  = drain_q;
        done_d   = done_q;
        math_x_d = math_x_q;
        math_y_d = math_y_q;
        tag_d    = tag_q;

        // The downstream ready stalls the whole block, including the FSM and tag pipe.
        if (en) begin
            tag_d[0] = TAG_NONE;
            for (int i = 1; i <= mem_latency; i++)
                tag_d[i] = tag_q[i-1];

            case (state_q)
                ST_IDLE: begin
                    u_d = '0;
                    v_d = '0;
                    if (Enable)
                        state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (issue) begin
                        math_x_d = XW'(u_q);
                        math_y_d = clamp_row(y_sum);
                        tag_d[0] = '{valid: 1'b1,
                                     last:  (u_q == U_LAST),
                                     user:  (u_q == '0) && (v_q == '0)};
                        if (u_q == U_LAST) begin
                            u_d = '0;
                            if (v_q == V_LAST) begin
                                v_d     = '0;
                                drain_d = '0;
                                state_d = ST_DRAIN;
                            end else begin
                                v_d = v_q + 1'b1;
                            end
                        end else begin
                            u_d = u_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Done is raised one cycle after the last tag leaves the pipe,
                    // then the next enabled cycle decides between a new frame and idle.
                    if (done_q) begin
                        done_d  = 1'b0;
                        drain_d = '0;
                        state_d = Enable ? ST_RUN : ST_IDLE;
                    end else if (drain_q == DW'(mem_latency)) begin
                        done_d = 1'b1;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            u_q      <= '0;
            v_q      <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            math_x_q <= '0;
            math_y_q <= '0;
            for (int i = 0; i <= mem_latency; i++)
                tag_q[i] <= TAG_NONE;
        end else begin
            state_q  <= state_d;
            u_q      <= u_d;
            v_q      <= v_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            math_x_q <= math_x_d;
            math_y_q <= math_y_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.Math_X      = math_x_q;
    assign bus.Math_Y      = math_y_q;
    assign bus.Pixel_Valid = tag_q[mem_latency].valid;
    assign bus.Pixel_Last  = tag_q[mem_latency].last;
    assign bus.Pixel_User  = tag_q[mem_latency].user;
    assign Frame_Done      = done_q;
    assign Busy            = (state_q != ST_IDLE);

endmodule
